// File: rtl/sysrow_pkg.sv
// Shared types and default sizing for the systolic row controller.
package sysrow_pkg;
    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_N_PE      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;
endpackage

// File: rtl/systolic_row_ctrl_if.sv
// Operand-beat and result handshakes of the systolic row controller.
interface systolic_row_ctrl_if
    import sysrow_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int N_PE      = DEF_N_PE
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WORD_SIZE-1:0]      in_a;
    logic [N_PE*WORD_SIZE-1:0] in_b;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_SIZE-1:0]      out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/systolic_row_ctrl_skew_line.sv
// DEPTH-stage shift register with synchronous zero reset; one per top-data lane.
module skew_line #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] d,
    output logic [WORD_SIZE-1:0] q
);
    logic [WORD_SIZE-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/systolic_row_ctrl.sv
// Feeds one row of N_PE PEs with skewed operands, then reads results out through PE0.
// Optional build macro SYSROW_PERF_EN adds the perf_beats output.
//
// state | meaning
// IDLE  | waiting for the first beat of a job
// CLEAR | one cycle of arr_reset to zero the accumulators
// FEED  | accepting beats, bubbles inject zero
// FLUSH | N_PE cycles letting the skewed lanes empty
// DRAIN | N_PE reads of PE results into the output register
module systolic_row_ctrl
    import sysrow_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int N_PE      = DEF_N_PE
) (
    input  logic                      clk,
    input  logic                      reset,
    systolic_row_ctrl_if.slave        bus,
    output logic                      arr_reset,
    output logic                      arr_read,
    output logic [WORD_SIZE-1:0]      arr_l_d,
    output logic [N_PE*WORD_SIZE-1:0] arr_t_d,
    input  logic [WORD_SIZE-1:0]      arr_l_q
`ifdef SYSROW_PERF_EN
    ,
    output logic [15:0]               perf_beats
`endif
);
    localparam int CW = $clog2(N_PE + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_PE - 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 in_ready_c;
    logic                 fire;
    logic                 out_valid_r, out_last_r;
    logic [WORD_SIZE-1:0] out_data_r;

    assign fire = bus.in_valid && in_ready_c;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid)                state_nxt = S_CLEAR;
            S_CLEAR:                                  state_nxt = S_FEED;
            S_FEED:  if (fire && bus.in_last)         state_nxt = S_FLUSH;
            S_FLUSH: if (cnt == LAST_IDX)             state_nxt = S_DRAIN;
            S_DRAIN: if (arr_read && cnt == LAST_IDX) state_nxt = S_IDLE;
            default:                                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        arr_read   = 1'b0;
        arr_reset  = reset;
        case (state)
            S_CLEAR: arr_reset  = 1'b1;
            S_FEED:  in_ready_c = !reset;
            S_DRAIN: arr_read   = !reset && (!out_valid_r || bus.out_ready);
            default: ;
        endcase
    end

    // Shared counter: FLUSH cycles, then DRAIN reads; cleared on every state change.
    always_ff @(posedge clk) begin
        if (reset || state != state_nxt)       cnt <= '0;
        else if (state == S_FLUSH || arr_read) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) arr_l_d <= '0;
        else       arr_l_d <= fire ? bus.in_a : '0;
    end

    for (genvar j = 0; j < N_PE; j++) begin : g_lane
        skew_line #(
            .WORD_SIZE (WORD_SIZE),
            .DEPTH     (j + 1)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .d     (fire ? bus.in_b[j*WORD_SIZE +: WORD_SIZE] : '0),
            .q     (arr_t_d[j*WORD_SIZE +: WORD_SIZE])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (arr_read) begin
            out_valid_r <= 1'b1;
            out_data_r  <= arr_l_q;
            out_last_r  <= (cnt == LAST_IDX);
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

`ifdef SYSROW_PERF_EN
    logic [15:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt   <= '0;
            perf_beats <= '0;
        end else begin
            if (state == S_CLEAR)                   beat_cnt <= '0;
            else if (fire && beat_cnt != 16'hFFFF)  beat_cnt <= beat_cnt + 16'd1;
            if (state == S_FLUSH && state_nxt == S_DRAIN) perf_beats <= beat_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_systolic_row_ctrl.sv
// Bench for systolic_row_ctrl with a four-PE row model and a result scoreboard.
module tb_systolic_row_ctrl;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int HN = 4096;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic arr_reset, arr_read;
    logic [W-1:0]   arr_l_d, arr_l_q;
    logic [N*W-1:0] arr_t_d;
`ifdef SYSROW_PERF_EN
    logic [15:0] perf_beats;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_row_ctrl_if #(.WORD_SIZE(W), .N_PE(N)) bus ();

    systolic_row_ctrl #(.WORD_SIZE(W), .N_PE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .arr_reset (arr_reset),
        .arr_read  (arr_read),
        .arr_l_d   (arr_l_d),
        .arr_t_d   (arr_t_d),
        .arr_l_q   (arr_l_q)
`ifdef SYSROW_PERF_EN
        ,
        .perf_beats (perf_beats)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Row of PEs: left data ripples right one PE per cycle, acc += l*t; read shifts accumulators toward PE0.
    logic [W-1:0] acc [N];
    logic [W-1:0] lreg [N];

    always @(posedge clk) begin
        if (arr_reset) begin
            for (int i = 0; i < N; i++) begin
                acc[i]  <= '0;
                lreg[i] <= '0;
            end
        end else if (arr_read) begin
            for (int i = 0; i < N - 1; i++) acc[i] <= acc[i+1];
            acc[N-1] <= '0;
        end else begin
            acc[0]  <= acc[0] + arr_l_d * arr_t_d[W-1:0];
            lreg[0] <= arr_l_d;
            for (int i = 1; i < N; i++) begin
                acc[i]  <= acc[i] + lreg[i-1] * arr_t_d[i*W +: W];
                lreg[i] <= lreg[i-1];
            end
        end
    end

    assign arr_l_q = acc[0];

    int             ecyc     = 0;
    int             last_rst = -1;
    logic [W-1:0]   hist_a [HN];
    logic [N*W-1:0] hist_b [HN];
    logic [W-1:0]   sum [N];
    res_t           exp_q[$];
    logic [W-1:0]   got_q[$];
    logic           got_l[$];
    logic           hold_v = 1'b0;
    logic [W-1:0]   hold_d;
    logic           hold_l;

    // Scoreboard: result of PE j = sum over the job's beats of a*b[j] mod 2^W.
    always @(posedge clk) begin
        res_t e;
        logic fire;
        ecyc++;
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out_unexpected: got word %0h, required no output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_last", bus.out_last, e.last);
            end
        end
        hold_v = bus.out_valid && !bus.out_ready && !reset;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
        fire = bus.in_valid && bus.in_ready;
        hist_a[ecyc % HN] = fire ? bus.in_a : '0;
        hist_b[ecyc % HN] = fire ? bus.in_b : '0;
        if (fire) begin
            for (int j = 0; j < N; j++) sum[j] = sum[j] + bus.in_a * bus.in_b[j*W +: W];
            if (bus.in_last) begin
                for (int j = 0; j < N; j++) begin
                    exp_q.push_back('{sum[j], (j == N - 1)});
                    sum[j] = '0;
                end
            end
        end
        if (reset) begin
            exp_q.delete();
            for (int j = 0; j < N; j++) sum[j] = '0;
            last_rst = ecyc;
            hold_v   = 1'b0;
        end
    end

    // Per-cycle checks: a beat accepted at edge e shows on arr_l_d after e and on lane j after e+j.
    always @(negedge clk) begin
        int n;
        n = ecyc;
        if (hold_v) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, hold_d);
            check("hold_last", bus.out_last, hold_l);
        end
        check("arr_l_d", arr_l_d, (n > last_rst) ? hist_a[n % HN] : '0);
        for (int j = 0; j < N; j++)
            check($sformatf("arr_t_d%0d", j), arr_t_d[j*W +: W],
                  (n - j > last_rst) ? hist_b[(n - j) % HN][j*W +: W] : '0);
        if (reset) check("arr_reset_in_reset", arr_reset, 1'b1);
    end

    logic       rdy_pat_en = 1'b0;
    logic [3:0] rdy_pat    = 4'b1001;

    initial begin
        int k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_pat_en ? rdy_pat[k % 4] : 1'b1;
            k++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [W-1:0] a, input logic [N*W-1:0] b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int k = 0; k < 300; k++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.in_a     = '0;
                bus.in_b     = '0;
                bus.in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("beat_accept_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input string name);
        int k = 0;
        while (got_q.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        gap(8);
        check({name, "_count"}, got_q.size(), n);
    endtask

    task automatic check_got(input string name, input int off, input logic [W-1:0] e0,
                             input logic [W-1:0] e1, input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] ev [4];
        ev = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_word%0d", name, off + i),
                  (got_q.size() > off + i) ? got_q[off + i] : 32'hDEAD, ev[i]);
    endtask

    initial begin
        int rd, k;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 16'h0000);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_arr_read", arr_read, 1'b0);
        check("rst_arr_l_d", arr_l_d, 16'h0000);
        check("rst_arr_t_d", arr_t_d, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // one beat: a=2, b={1,2,3,4}
        got_q.delete();
        got_l.delete();
        bus.in_valid = 1'b1;
        bus.in_a     = 16'd2;
        bus.in_b     = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.in_last  = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b0);
        check("idle_arr_reset", arr_reset, 1'b0);
        @(negedge clk);
        check("clear_arr_reset", arr_reset, 1'b1);
        check("clear_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("feed_arr_reset", arr_reset, 1'b0);
        check("feed_in_ready", bus.in_ready, 1'b1);
        send_beat(16'd2, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
        wait_out(4, "one_beat");
        check_got("one_beat", 0, 16'd2, 16'd4, 16'd6, 16'd8);
        check("one_beat_last_on_8", (got_l.size() == 4) ? got_l[3] : 1'b0, 1'b1);
        check("one_beat_nolast_on_2", (got_l.size() == 4) ? got_l[0] : 1'b1, 1'b0);

        // two beats
        got_q.delete();
        send_beat(16'd1, {4{16'd1}}, 1'b0);
        send_beat(16'd3, {4{16'd2}}, 1'b1);
        wait_out(4, "two_beat");
        check_got("two_beat", 0, 16'd7, 16'd7, 16'd7, 16'd7);

        // accumulator wrap
        got_q.delete();
        send_beat(16'h0100, {4{16'h0100}}, 1'b1);
        wait_out(4, "wrap");
        check_got("wrap", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // bubbles and backpressure
        got_q.delete();
        rdy_pat_en = 1'b1;
        send_beat(16'd1, {4{16'd1}}, 1'b0);
        gap(3);
        send_beat(16'd3, {4{16'd2}}, 1'b1);
        wait_out(4, "bubble");
        check_got("bubble", 0, 16'd7, 16'd7, 16'd7, 16'd7);
        rdy_pat_en = 1'b0;
        gap(2);

        // reset on the second drain read
        got_q.delete();
        send_beat(16'd2, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
        rd = 0;
        k  = 0;
        while (rd < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (arr_read) rd++;
        end
        check("midreset_reads_seen", rd, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out_valid", bus.out_valid, 1'b0);
        reset = 1'b0;
        gap(8);
        check("midreset_words", got_q.size(), 1);
        check("midreset_first_word", (got_q.size() > 0) ? got_q[0] : 32'hDEAD, 16'd2);
        got_q.delete();
        send_beat(16'd5, {4{16'd1}}, 1'b1);
        wait_out(4, "after_reset");
        check_got("after_reset", 0, 16'd5, 16'd5, 16'd5, 16'd5);

        // back-to-back jobs with in_valid held high
        got_q.delete();
        fork
            begin
                send_beat(16'd1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
                send_beat(16'd2, {16'd1, 16'd2, 16'd3, 16'd4}, 1'b1);
            end
            begin
                int r2 = 0;
                int k2 = 0;
                while (r2 < 4 && k2 < 100) begin
                    @(negedge clk);
                    k2++;
                    if (arr_read) r2++;
                end
                check("b2b_reads_seen", r2, 4);
                @(negedge clk);
                check("b2b_idle_after_read", arr_reset, 1'b0);
                @(negedge clk);
                check("b2b_clear_follows", arr_reset, 1'b1);
            end
        join
        wait_out(8, "b2b");
        check_got("b2b", 0, 16'd1, 16'd2, 16'd3, 16'd4);
        check_got("b2b", 4, 16'd8, 16'd6, 16'd4, 16'd2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
